// File: rtl/cache_lookup_client_if.sv
// Cache line types and the req/gnt tag-compare arbiter port driven by cache_lookup_client.
package std_cache_pkg;
    localparam int unsigned DCACHE_TAG_WIDTH  = 44;
    localparam int unsigned DCACHE_LINE_WIDTH = 128;
    localparam int unsigned DCACHE_WAYS       = 8;

    typedef struct packed {
        logic [DCACHE_TAG_WIDTH-1:0]  tag;
        logic [DCACHE_LINE_WIDTH-1:0] data;
        logic                         valid;
        logic                         dirty;
    } cache_line_t;

    typedef struct packed {
        logic [(DCACHE_TAG_WIDTH+7)/8-1:0] tag;
        logic [DCACHE_LINE_WIDTH/8-1:0]    data;
        logic [DCACHE_WAYS-1:0]            vldrty;
    } cl_be_t;
endpackage

interface cache_lookup_client_if #(
    parameter int unsigned ADDR_WIDTH       = 64,
    parameter int unsigned TAG_WIDTH        = 44,
    parameter int unsigned DCACHE_SET_ASSOC = 8,
    parameter type         l_data_t         = std_cache_pkg::cache_line_t,
    parameter type         l_be_t           = std_cache_pkg::cl_be_t
);
    logic [DCACHE_SET_ASSOC-1:0]          req_o;
    logic                                 gnt_i;
    logic [ADDR_WIDTH-1:0]                addr_o;
    logic [TAG_WIDTH-1:0]                 tag_o;
    logic                                 we_o;
    l_data_t                              wdata_o;
    l_be_t                                be_o;
    l_data_t [DCACHE_SET_ASSOC-1:0]       rdata_i;
    logic [DCACHE_SET_ASSOC-1:0]          hit_way_i;

    modport master (
        output req_o, addr_o, tag_o, we_o, wdata_o, be_o,
        input  gnt_i, rdata_i, hit_way_i
    );

    modport slave (
        input  req_o, addr_o, tag_o, we_o, wdata_o, be_o,
        output gnt_i, rdata_i, hit_way_i
    );
endinterface

// File: rtl/cache_lookup_client.sv
// Single-command initiator for the data-cache tag-compare arbiter: request all ways,
// present the tag after grant, resolve the hit way, optionally write it, then respond.
module cache_lookup_client #(
    parameter int unsigned ADDR_WIDTH       = 64,
    parameter int unsigned INDEX_WIDTH      = 12,
    parameter int unsigned TAG_WIDTH        = 44,
    parameter int unsigned DCACHE_SET_ASSOC = 8,
    parameter type         l_data_t         = std_cache_pkg::cache_line_t,
    parameter type         l_be_t           = std_cache_pkg::cl_be_t
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        cmd_valid_i,
    output logic                        cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0]       cmd_addr_i,
    input  logic                        cmd_we_i,
    input  l_data_t                     cmd_wdata_i,
    input  l_be_t                       cmd_be_i,
    output logic                        rsp_valid_o,
    input  logic                        rsp_ready_i,
    output logic                        rsp_hit_o,
    output logic [DCACHE_SET_ASSOC-1:0] rsp_way_o,
    output l_data_t                     rsp_rdata_o,
    output logic                        err_o,
    cache_lookup_client_if.master       arb
);

    typedef enum logic [2:0] {IDLE, REQ, CMP, WRITE, RESP} state_e;

    state_e                      state_q;
    logic [INDEX_WIDTH-1:0]      index_q;
    logic [TAG_WIDTH-1:0]        tag_q;
    logic                        we_q;
    l_data_t                     wdata_q;
    l_be_t                       be_q;

    logic [DCACHE_SET_ASSOC-1:0] sel_way;
    l_data_t                     sel_line;
    logic                        any_hit;
    logic                        multi_hit;

    function automatic logic [DCACHE_SET_ASSOC-1:0] lowest_way(
        input logic [DCACHE_SET_ASSOC-1:0] hits
    );
        lowest_way = '0;
        for (int i = DCACHE_SET_ASSOC - 1; i >= 0; i--) begin
            if (hits[i]) begin
                lowest_way    = '0;
                lowest_way[i] = 1'b1;
            end
        end
    endfunction

    function automatic logic more_than_one(input logic [DCACHE_SET_ASSOC-1:0] hits);
        more_than_one = ($countones(hits) > 1);
    endfunction

    generate
        if (ADDR_WIDTH > INDEX_WIDTH + TAG_WIDTH) begin : g_addr_msb
            logic unused_addr_msb;
            assign unused_addr_msb = ^cmd_addr_i[ADDR_WIDTH-1:INDEX_WIDTH+TAG_WIDTH];
        end
    endgenerate

    assign any_hit   = |arb.hit_way_i;
    assign multi_hit = more_than_one(arb.hit_way_i);
    assign sel_way   = lowest_way(arb.hit_way_i);

    always_comb begin
        sel_line = '0;
        for (int i = 0; i < DCACHE_SET_ASSOC; i++) begin
            if (sel_way[i]) sel_line = arb.rdata_i[i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            index_q     <= '0;
            tag_q       <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            be_q        <= '0;
            cmd_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_hit_o   <= 1'b0;
            rsp_way_o   <= '0;
            rsp_rdata_o <= '0;
            err_o       <= 1'b0;
            arb.req_o   <= '0;
            arb.addr_o  <= '0;
            arb.tag_o   <= '0;
            arb.we_o    <= 1'b0;
            arb.wdata_o <= '0;
            arb.be_o    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        index_q     <= cmd_addr_i[INDEX_WIDTH-1:0];
                        tag_q       <= cmd_addr_i[INDEX_WIDTH +: TAG_WIDTH];
                        we_q        <= cmd_we_i;
                        wdata_q     <= cmd_wdata_i;
                        be_q        <= cmd_be_i;
                        cmd_ready_o <= 1'b0;
                        arb.req_o   <= '1;
                        arb.addr_o  <= ADDR_WIDTH'(cmd_addr_i[INDEX_WIDTH-1:0]);
                        state_q     <= REQ;
                    end
                end
                // request phase: all ways, index held until the arbiter grants
                REQ: begin
                    if (arb.gnt_i) begin
                        arb.req_o  <= '0;
                        arb.addr_o <= '0;
                        arb.tag_o  <= tag_q;
                        state_q    <= CMP;
                    end
                end
                // compare phase: ways answer with hit vector and lines this cycle
                CMP: begin
                    arb.tag_o   <= '0;
                    rsp_hit_o   <= any_hit;
                    rsp_way_o   <= sel_way;
                    rsp_rdata_o <= sel_line;
                    if (multi_hit) err_o <= 1'b1;
                    if (we_q && any_hit) begin
                        arb.req_o   <= sel_way;
                        arb.we_o    <= 1'b1;
                        arb.addr_o  <= ADDR_WIDTH'(index_q);
                        arb.wdata_o <= wdata_q;
                        arb.be_o    <= be_q;
                        state_q     <= WRITE;
                    end else begin
                        rsp_valid_o <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                // write phase: only the resolved way, held until granted
                WRITE: begin
                    if (arb.gnt_i) begin
                        arb.req_o   <= '0;
                        arb.we_o    <= 1'b0;
                        arb.addr_o  <= '0;
                        arb.wdata_o <= '0;
                        arb.be_o    <= '0;
                        rsp_valid_o <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        cmd_ready_o <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_lookup_client.sv
// Bench for cache_lookup_client: a reactive arbiter/cache stand-in plus a phase-level reference model.
module tb_cache_lookup_client;
    localparam int unsigned AW = 64;
    localparam int unsigned IW = 12;
    localparam int unsigned TW = 44;
    localparam int unsigned NW = 8;

    typedef std_cache_pkg::cache_line_t line_t;
    typedef std_cache_pkg::cl_be_t      be_t;

    typedef struct packed {
        logic [NW-1:0] req;
        logic          we;
        logic [AW-1:0] addr;
        logic [TW-1:0] tag;
        line_t         wdata;
        be_t           be;
        logic          rsp_valid;
        logic          cmd_ready;
    } snap_t;

    logic          clk_i       = 1'b0;
    logic          rst_ni      = 1'b0;
    logic          cmd_valid_i = 1'b0;
    logic          cmd_ready_o;
    logic [AW-1:0] cmd_addr_i  = '0;
    logic          cmd_we_i    = 1'b0;
    line_t         cmd_wdata_i = '0;
    be_t           cmd_be_i    = '0;
    logic          rsp_valid_o;
    logic          rsp_ready_i = 1'b0;
    logic          rsp_hit_o;
    logic [NW-1:0] rsp_way_o;
    line_t         rsp_rdata_o;
    logic          err_o;

    int    passed = 0;
    int    total  = 0;
    snap_t trace[$];
    line_t way_lines[NW];
    logic  err_exp = 1'b0;

    always #5 clk_i = ~clk_i;

    cache_lookup_client_if #(.ADDR_WIDTH(AW), .TAG_WIDTH(TW), .DCACHE_SET_ASSOC(NW)) arb ();

    cache_lookup_client #(
        .ADDR_WIDTH(AW), .INDEX_WIDTH(IW), .TAG_WIDTH(TW), .DCACHE_SET_ASSOC(NW)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_addr_i(cmd_addr_i),
        .cmd_we_i(cmd_we_i), .cmd_wdata_i(cmd_wdata_i), .cmd_be_i(cmd_be_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_hit_o(rsp_hit_o),
        .rsp_way_o(rsp_way_o), .rsp_rdata_o(rsp_rdata_o), .err_o(err_o),
        .arb(arb)
    );

    function automatic line_t rand_line();
        logic [191:0] r;
        for (int i = 0; i < 6; i++) r[i*32 +: 32] = $urandom;
        return line_t'(r[$bits(line_t)-1:0]);
    endfunction

    function automatic be_t rand_be();
        logic [31:0] r;
        r = $urandom;
        return be_t'(r[$bits(be_t)-1:0]);
    endfunction

    function automatic snap_t take_snap();
        snap_t s;
        s.req       = arb.req_o;
        s.we        = arb.we_o;
        s.addr      = arb.addr_o;
        s.tag       = arb.tag_o;
        s.wdata     = arb.wdata_o;
        s.be        = arb.be_o;
        s.rsp_valid = rsp_valid_o;
        s.cmd_ready = cmd_ready_o;
        return s;
    endfunction

    // Issues one command and plays arbiter/cache until rsp_valid_o; records one snapshot per cycle.
    task automatic do_cmd(input logic [AW-1:0] a, input logic we, input line_t wd, input be_t be,
                          input logic [NW-1:0] hit, input int rdly, input int wdly);
        int   wcnt     = 0;
        int   waited   = 0;
        logic read_gnt = 1'b0;
        trace.delete();
        while (!cmd_ready_o && waited < 10) begin
            @(posedge clk_i); #1;
            waited++;
        end
        if (!cmd_ready_o) begin
            total++;
            $display("FAIL accept_timeout: cmd_ready_o=%b required 1", cmd_ready_o);
        end
        cmd_valid_i = 1'b1; cmd_addr_i = a; cmd_we_i = we; cmd_wdata_i = wd; cmd_be_i = be;
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (read_gnt) begin
                arb.hit_way_i = hit;
                for (int w = 0; w < NW; w++) arb.rdata_i[w] = way_lines[w];
            end else begin
                arb.hit_way_i = '0;
                arb.rdata_i   = '0;
            end
            trace.push_back(take_snap());
            if (rsp_valid_o) break;
            if (arb.req_o != '0) begin
                if (wcnt >= (arb.we_o ? wdly : rdly)) begin
                    arb.gnt_i = 1'b1;
                    wcnt      = 0;
                end else begin
                    arb.gnt_i = 1'b0;
                    wcnt++;
                end
            end else begin
                arb.gnt_i = 1'b0;
                wcnt      = 0;
            end
            read_gnt = arb.gnt_i && !arb.we_o;
            @(posedge clk_i); #1;
        end
        arb.gnt_i     = 1'b0;
        arb.hit_way_i = '0;
        arb.rdata_i   = '0;
    endtask

    task automatic release_rsp();
        rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        rsp_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        total++;
        if (cmd_ready_o !== 1'b1) $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready_o);
        else passed++;
        total++;
        if ({rsp_valid_o, rsp_hit_o, rsp_way_o, rsp_rdata_o, err_o, arb.req_o, arb.we_o,
             arb.addr_o, arb.tag_o, arb.wdata_o, arb.be_o} !== '0)
            $display("FAIL reset_outputs: rsp_valid=%b req=%h we=%b addr=%h tag=%h err=%b want all 0",
                     rsp_valid_o, arb.req_o, arb.we_o, arb.addr_o, arb.tag_o, err_o);
        else passed++;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        total++;
        if ({cmd_ready_o, rsp_valid_o, arb.req_o} !== {1'b1, 1'b0, 8'h00})
            $display("FAIL idle_after_reset: ready=%b valid=%b req=%h want 1 0 00",
                     cmd_ready_o, rsp_valid_o, arb.req_o);
        else passed++;
    endtask

    task automatic test_read_hit();
        for (int w = 0; w < NW; w++) way_lines[w] = rand_line();
        way_lines[3].tag   = 44'h12345;
        way_lines[3].valid = 1'b1;
        do_cmd(64'h0000_1234_5678, 1'b0, '0, '0, 8'h08, 0, 0);
        total++;
        if (trace.size() != 3) $display("FAIL read_hit_latency: rsp after %0d cycles want 3", trace.size());
        else passed++;
        total++;
        if ({trace[0].req, trace[0].addr, trace[0].we} !== {8'hFF, 64'h678, 1'b0})
            $display("FAIL read_hit_req: req=%h addr=%h we=%b want ff 678 0",
                     trace[0].req, trace[0].addr, trace[0].we);
        else passed++;
        total++;
        if ({trace[1].tag, trace[1].req} !== {44'h12345, 8'h00})
            $display("FAIL read_hit_tag: tag=%h req=%h want 12345 00", trace[1].tag, trace[1].req);
        else passed++;
        total++;
        if ({trace[2].rsp_valid, rsp_hit_o, rsp_way_o} !== {1'b1, 1'b1, 8'h08})
            $display("FAIL read_hit_rsp: valid=%b hit=%b way=%h want 1 1 08",
                     trace[2].rsp_valid, rsp_hit_o, rsp_way_o);
        else passed++;
        total++;
        if (rsp_rdata_o !== way_lines[3])
            $display("FAIL read_hit_rdata: got %h want %h", rsp_rdata_o, way_lines[3]);
        else passed++;
        release_rsp();
        total++;
        if ({rsp_valid_o, cmd_ready_o} !== 2'b01)
            $display("FAIL read_hit_release: valid=%b ready=%b want 0 1", rsp_valid_o, cmd_ready_o);
        else passed++;
    endtask

    task automatic test_read_miss();
        int writes;
        for (int pass = 0; pass < 2; pass++) begin
            for (int w = 0; w < NW; w++) way_lines[w] = rand_line();
            do_cmd({$urandom, $urandom}, pass[0], rand_line(), rand_be(), '0, 0, 0);
            writes = 0;
            foreach (trace[i]) if (trace[i].we || (trace[i].req != 8'hFF && trace[i].req != 8'h00)) writes++;
            total++;
            if (trace.size() != 3 || writes != 0)
                $display("FAIL miss_no_write[we=%0d]: cycles=%0d write_cycles=%0d want 3 0", pass, trace.size(), writes);
            else passed++;
            total++;
            if ({rsp_hit_o, rsp_way_o, rsp_rdata_o} !== '0)
                $display("FAIL miss_rsp[we=%0d]: hit=%b way=%h rdata=%h want all 0", pass, rsp_hit_o, rsp_way_o, rsp_rdata_o);
            else passed++;
            release_rsp();
        end
    endtask

    task automatic test_write_hit();
        line_t wd;
        wd = rand_line();
        for (int w = 0; w < NW; w++) way_lines[w] = rand_line();
        do_cmd({$urandom, $urandom}, 1'b1, wd, '1, 8'h20, 0, 2);
        total++;
        if (trace.size() != 6) $display("FAIL write_hit_latency: rsp after %0d cycles want 6", trace.size());
        else passed++;
        for (int i = 2; i < 5; i++) begin
            total++;
            if ({trace[i].req, trace[i].we, trace[i].wdata, trace[i].be, trace[i].tag} !== {8'h20, 1'b1, wd, be_t'('1), 44'h0})
                $display("FAIL write_hold[%0d]: req=%h we=%b be=%h want 20 1 %h", i, trace[i].req, trace[i].we, trace[i].be, be_t'('1));
            else passed++;
        end
        total++;
        if ({trace[5].rsp_valid, trace[5].req, trace[5].we, rsp_hit_o, rsp_way_o} !== {1'b1, 8'h00, 1'b0, 1'b1, 8'h20})
            $display("FAIL write_hit_rsp: valid=%b req=%h we=%b hit=%b way=%h want 1 00 0 1 20",
                     trace[5].rsp_valid, trace[5].req, trace[5].we, rsp_hit_o, rsp_way_o);
        else passed++;
        total++;
        if (rsp_rdata_o !== way_lines[5]) $display("FAIL write_prewrite_rdata: got %h want %h", rsp_rdata_o, way_lines[5]);
        else passed++;
        release_rsp();
    endtask

    task automatic test_gnt_stall();
        logic [AW-1:0] a;
        a = {$urandom, $urandom};
        for (int w = 0; w < NW; w++) way_lines[w] = rand_line();
        do_cmd(a, 1'b0, '0, '0, 8'h01, 4, 0);
        total++;
        if (trace.size() != 7) $display("FAIL stall_latency: rsp after %0d cycles want 7", trace.size());
        else passed++;
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({trace[i].req, trace[i].addr, trace[i].tag} !== {8'hFF, AW'(a[IW-1:0]), 44'h0})
                $display("FAIL stall_req[%0d]: req=%h addr=%h tag=%h want ff %h 0", i, trace[i].req, trace[i].addr, trace[i].tag, a[IW-1:0]);
            else passed++;
        end
        total++;
        if ({trace[5].req, trace[5].tag} !== {8'h00, a[IW +: TW]})
            $display("FAIL stall_tag: req=%h tag=%h want 00 %h", trace[5].req, trace[5].tag, a[IW +: TW]);
        else passed++;
        release_rsp();
    endtask

    task automatic test_multi_hit();
        for (int w = 0; w < NW; w++) way_lines[w] = rand_line();
        do_cmd({$urandom, $urandom}, 1'b0, '0, '0, 8'h12, 0, 0);
        err_exp = 1'b1;
        total++;
        if ({rsp_hit_o, rsp_way_o, err_o} !== {1'b1, 8'h02, 1'b1})
            $display("FAIL multi_hit: hit=%b way=%h err=%b want 1 02 1", rsp_hit_o, rsp_way_o, err_o);
        else passed++;
        total++;
        if (rsp_rdata_o !== way_lines[1]) $display("FAIL multi_hit_rdata: got %h want %h", rsp_rdata_o, way_lines[1]);
        else passed++;
        release_rsp();
        do_cmd({$urandom, $urandom}, 1'b0, '0, '0, 8'h40, 1, 0);
        total++;
        if ({rsp_way_o, err_o} !== {8'h40, 1'b1})
            $display("FAIL err_sticky: way=%h err=%b want 40 1", rsp_way_o, err_o);
        else passed++;
        release_rsp();
    endtask

    task automatic test_reset_during_write();
        for (int w = 0; w < NW; w++) way_lines[w] = rand_line();
        cmd_valid_i = 1'b1; cmd_addr_i = {$urandom, $urandom}; cmd_we_i = 1'b1;
        cmd_wdata_i = rand_line(); cmd_be_i = rand_be();
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b0;
        arb.gnt_i = 1'b1;
        @(posedge clk_i); #1;
        arb.gnt_i     = 1'b0;
        arb.hit_way_i = 8'h04;
        for (int w = 0; w < NW; w++) arb.rdata_i[w] = way_lines[w];
        @(posedge clk_i); #1;
        arb.hit_way_i = '0;
        arb.rdata_i   = '0;
        total++;
        if ({arb.req_o, arb.we_o} !== {8'h04, 1'b1})
            $display("FAIL rst_write_entry: req=%h we=%b want 04 1", arb.req_o, arb.we_o);
        else passed++;
        #2 rst_ni = 1'b0;
        #1;
        total++;
        if ({cmd_ready_o, rsp_valid_o, err_o, arb.req_o, arb.we_o, arb.addr_o, arb.wdata_o, arb.be_o} !==
            {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 64'h0, line_t'('0), be_t'('0)})
            $display("FAIL rst_async_clear: ready=%b valid=%b err=%b req=%h we=%b addr=%h want 1 0 0 00 0 0",
                     cmd_ready_o, rsp_valid_o, err_o, arb.req_o, arb.we_o, arb.addr_o);
        else passed++;
        err_exp = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        do_cmd({$urandom, $urandom}, 1'b0, '0, '0, 8'h80, 0, 0);
        total++;
        if ({trace.size() == 3, rsp_hit_o, rsp_way_o, rsp_rdata_o, err_o} !== {1'b1, 1'b1, 8'h80, way_lines[7], 1'b0})
            $display("FAIL rst_next_cmd: cycles=%0d hit=%b way=%h err=%b want 3 1 80 0",
                     trace.size(), rsp_hit_o, rsp_way_o, err_o);
        else passed++;
        release_rsp();
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        logic          we, exp_hit;
        line_t         wd, exp_line;
        be_t           be;
        logic [NW-1:0] hit, exp_way;
        int            rdly, wdly, hold;
        snap_t         s, t;
        snap_t         exp_q[$];
        for (int it = 0; it < 40; it++) begin
            a = {$urandom, $urandom};
            we = 1'($urandom_range(0, 1));
            wd = rand_line();
            be = rand_be();
            case ($urandom_range(0, 3))
                0:       hit = '0;
                3:       hit = NW'($urandom);
                default: hit = 8'd1 << $urandom_range(0, 7);
            endcase
            rdly = $urandom_range(0, 3);
            wdly = $urandom_range(0, 3);
            hold = $urandom_range(0, 2);
            for (int w = 0; w < NW; w++) way_lines[w] = rand_line();
            // reference: phases REQ x(rdly+1), CMP, optional WRITE x(wdly+1), then RESP
            exp_way  = hit & (~hit + 8'd1);
            exp_hit  = (hit != '0);
            exp_line = exp_hit ? way_lines[$clog2(exp_way)] : '0;
            if ($countones(hit) > 1) err_exp = 1'b1;
            exp_q.delete();
            for (int i = 0; i <= rdly; i++) begin
                s = '0; s.req = '1; s.addr = AW'(a[IW-1:0]);
                exp_q.push_back(s);
            end
            s = '0; s.tag = a[IW +: TW];
            exp_q.push_back(s);
            if (we && exp_hit) begin
                for (int i = 0; i <= wdly; i++) begin
                    s = '0; s.req = exp_way; s.we = 1'b1; s.addr = AW'(a[IW-1:0]); s.wdata = wd; s.be = be;
                    exp_q.push_back(s);
                end
            end
            s = '0; s.rsp_valid = 1'b1;
            exp_q.push_back(s);

            do_cmd(a, we, wd, be, hit, rdly, wdly);
            total++;
            if (trace.size() != exp_q.size())
                $display("FAIL rand_latency[%0d]: rsp after %0d cycles want %0d", it, trace.size(), exp_q.size());
            else begin
                passed++;
                for (int i = 0; i < exp_q.size(); i++) begin
                    t = trace[i];
                    if (exp_q[i].req == '0) t.addr = '0;
                    total++;
                    if (t !== exp_q[i]) $display("FAIL rand_cycle[%0d.%0d]: got %h want %h", it, i, t, exp_q[i]);
                    else passed++;
                end
            end
            total++;
            if ({rsp_hit_o, rsp_way_o, rsp_rdata_o, err_o} !== {exp_hit, exp_way, exp_line, err_exp})
                $display("FAIL rand_rsp[%0d]: hit=%b way=%h err=%b want %b %h %b (hits %h)",
                         it, rsp_hit_o, rsp_way_o, err_o, exp_hit, exp_way, err_exp, hit);
            else passed++;
            for (int h = 0; h < hold; h++) begin
                @(posedge clk_i); #1;
                total++;
                if ({rsp_valid_o, rsp_hit_o, rsp_way_o, rsp_rdata_o, cmd_ready_o} !== {1'b1, exp_hit, exp_way, exp_line, 1'b0})
                    $display("FAIL rand_hold[%0d.%0d]: valid=%b way=%h ready=%b want 1 %h 0", it, h, rsp_valid_o, rsp_way_o, cmd_ready_o, exp_way);
                else passed++;
            end
            release_rsp();
            total++;
            if ({rsp_valid_o, cmd_ready_o} !== 2'b01)
                $display("FAIL rand_release[%0d]: valid=%b ready=%b want 0 1", it, rsp_valid_o, cmd_ready_o);
            else passed++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        arb.gnt_i     = 1'b0;
        arb.hit_way_i = '0;
        arb.rdata_i   = '0;
        test_reset();
        test_read_hit();
        test_read_miss();
        test_write_hit();
        test_gnt_stall();
        test_multi_hit();
        test_reset_during_write();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/cache_lookup_client.md
Name: cache_lookup_client

Overview:
- Initiator side of the data-cache tag-compare arbiter port.
- Accepts one lookup or write command at a time from an upstream unit, such as a miss handler, flush walker or store path.
- Drives the simplified req/gnt protocol across all ways, presents the tag one cycle after grant, then resolves the hit way.
- Optionally writes the hit way, then returns hit status and line contents upstream.

Parameters:
- ADDR_WIDTH, 64, width of command address and addr_o.
- INDEX_WIDTH, 12, low address bits forming the set index driven on addr_o.
- TAG_WIDTH, 44, tag bits taken from cmd_addr_i[INDEX_WIDTH +: TAG_WIDTH].
- DCACHE_SET_ASSOC, 8, number of ways.
- l_data_t, std_cache_pkg::cache_line_t, line type with fields tag, data, valid, dirty.
- l_be_t, std_cache_pkg::cl_be_t, byte-enable type matching l_data_t.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  command accepted when high together with cmd_valid_i.
- cmd_addr_i  in  ADDR_WIDTH  physical address.
- cmd_we_i  in  1  write on hit.
- cmd_wdata_i  in  l_data_t  write data.
- cmd_be_i  in  l_be_t  write byte enables.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed.
- rsp_hit_o  out  1  lookup hit.
- rsp_way_o  out  DCACHE_SET_ASSOC  one-hot hit way, or 0 on miss.
- rsp_rdata_o  out  l_data_t  line of the hit way before any write; '0 on miss.
- err_o  out  1  sticky multi-hit error.
- req_o  out  DCACHE_SET_ASSOC  per-way request to the arbiter.
- gnt_i  in  1  grant, combinational in the same cycle as req_o.
- addr_o  out  ADDR_WIDTH  zero-extended set index.
- tag_o  out  TAG_WIDTH  compare tag.
- we_o  out  1  write enable.
- wdata_o  out  l_data_t  write data.
- be_o  out  l_be_t  byte enables.
- rdata_i  in  DCACHE_SET_ASSOC x l_data_t  per-way read lines.
- hit_way_i  in  DCACHE_SET_ASSOC  per-way hit vector.

Behaviour:
- Reset (async, any state): FSM to IDLE, all outputs 0 except cmd_ready_o=1, command registers cleared. err_o clears only on reset.
- FSM states: IDLE, REQ, CMP, WRITE, RESP.
- IDLE:
  - cmd_ready_o=1.
  - On cmd_valid_i, register addr/we/wdata/be and go to REQ.
- REQ:
  - req_o all ones, we_o=0, addr_o = registered index.
  - Hold req_o and addr_o stable until gnt_i=1, then go to CMP.
- CMP (always exactly one cycle, the cycle after grant):
  - tag_o = registered tag; req_o=0.
  - Sample hit_way_i and rdata_i.
  - On multi-hit (popcount>1), set err_o and select the lowest-index hit way.
  - Capture rsp_way, rsp_hit and the selected rdata_i entry.
  - If we and hit, go to WRITE; otherwise go to RESP.
- WRITE:
  - req_o = one-hot hit way, we_o=1, addr_o = index, wdata_o/be_o = registered values.
  - Hold until gnt_i, then go to RESP.
  - tag_o is don't-care here; drive it 0.
- RESP:
  - rsp_valid_o=1, response outputs stable.
  - Go to IDLE when rsp_ready_i=1.
  - No back-to-back acceptance: cmd_ready_o=0 in RESP.
- Write on miss: no WRITE state; respond with hit=0.
- Outside REQ/WRITE: req_o, we_o, wdata_o and be_o are 0. tag_o is 0 outside CMP.
- Latency with immediate grants:
  - Read: command accepted cycle 0, req cycle 1, CMP cycle 2, rsp_valid_o from cycle 3.
  - Write hit: rsp_valid_o from cycle 4.
- Grant withheld N cycles extends REQ (or WRITE) by N cycles; no other effect.

Test Plan:
- Read hit, gnt_i tied 1, addr 0x0000_1234_5678, way 3 valid with matching tag:
  - req_o=8'hFF in cycle 1, addr_o=0x678, tag_o=0x1234_5 in cycle 2.
  - rsp_valid_o cycle 3, rsp_hit_o=1, rsp_way_o=8'h08, rsp_rdata_o=rdata_i[3].
- Read miss (no valid tag match) -> rsp_hit_o=0, rsp_way_o=0, no WRITE request issued.
- Write hit, way 5, be all ones, gnt_i delayed 2 cycles in WRITE:
  - req_o=8'h20 and we_o=1 held for 3 cycles.
  - rsp_valid_o one cycle after grant; rsp_rdata_o holds the pre-write line.
- gnt_i low for 4 cycles in REQ -> req_o=8'hFF and addr_o stable for 5 cycles, tag_o presented only the cycle after grant.
- Multi-hit, hit_way_i=8'h12 -> rsp_way_o=8'h02, err_o=1 and stays 1 until reset.
- rst_ni asserted during WRITE -> outputs cleared immediately, cmd_ready_o=1 after release, next command proceeds normally.
